// File: rtl/vec_tile_serializer.sv
// Vector-to-tile serializer: captures one LENGTH-element vector per handshake and
// streams it as TILE-wide beats, zero-padding elements at or beyond the runtime length.

module vec_tile_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE       = 16,
  parameter int NBEATS     = 8,
  parameter int LANE       = 0,
  parameter int LW         = 8,
  parameter int IW         = 3
)(
  input  logic [NBEATS-1:0][DATA_WIDTH-1:0] col,
  input  logic [IW-1:0]                     idx,
  input  logic [LW-1:0]                     eff_len,
  input  logic                              en,
  output logic [DATA_WIDTH-1:0]             elem
);
  logic [31:0] k;
  assign k    = 32'(idx) * 32'(TILE) + 32'(LANE);
  assign elem = (en && k < 32'(eff_len)) ? col[idx] : '0;
endmodule

module vec_tile_serializer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int LENGTH     = 128,
  parameter  int TILE       = 16,
  localparam int NBEATS     = LENGTH / TILE,
  localparam int LW         = $clog2(LENGTH + 1),
  localparam int IW         = (NBEATS > 1) ? $clog2(NBEATS) : 1
)(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]  in_vec,
  input  logic [LW-1:0]                      vec_len,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [TILE-1:0][DATA_WIDTH-1:0]    out_tile,
  output logic [IW-1:0]                      out_idx,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);
  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  typedef struct packed {
    logic [LW-1:0] eff_len;
    logic [IW-1:0] last_idx;
  } meta_t;

  state_t                           state;
  meta_t                            meta;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] buffer;
  logic [LW-1:0]                    eff_in;
  int                               nb_in;
  logic [IW-1:0]                    nxt_idx;

  always_comb begin
    eff_in  = (int'(vec_len) > LENGTH) ? LW'(LENGTH) : vec_len;
    nb_in   = (int'(eff_in) + TILE - 1) / TILE;
    nxt_idx = out_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      meta      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            buffer        <= in_vec;
            meta.eff_len  <= eff_in;
            meta.last_idx <= IW'(nb_in - 1);
            out_idx       <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b1;
            // An empty vector still owes the writer a done pulse.
            if (nb_in != 0) begin
              state     <= SEND;
              out_valid <= 1'b1;
              out_last  <= (nb_in == 1);
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= FIN;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= nxt_idx;
              out_last <= (nxt_idx == meta.last_idx);
            end
          end
        end
        FIN: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane j owns column j of the buffer, one element per beat.
  logic [TILE-1:0][NBEATS-1:0][DATA_WIDTH-1:0] cols;

  for (genvar j = 0; j < TILE; j++) begin : g_lane
    for (genvar b = 0; b < NBEATS; b++) begin : g_col
      assign cols[j][b] = buffer[b*TILE + j];
    end
    vec_tile_lane #(
      .DATA_WIDTH(DATA_WIDTH), .TILE(TILE), .NBEATS(NBEATS),
      .LANE(j), .LW(LW), .IW(IW)
    ) u_lane (
      .col    (cols[j]),
      .idx    (out_idx),
      .eff_len(meta.eff_len),
      .en     (out_valid),
      .elem   (out_tile[j])
    );
  end
endmodule

// File: tb/tb_vec_tile_serializer.sv
// Directed + randomized bench for vec_tile_serializer against a per-element reference model.
module tb_vec_tile_serializer;
  localparam int DW = 8, LENGTH = 128, TILE = 16, IW = 3, LW = 8;
  typedef logic [LENGTH-1:0][DW-1:0] vec_t;
  typedef logic [TILE-1:0][DW-1:0]   tile_t;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  vec_t in_vec = '0;
  logic [LW-1:0] vec_len = '0;
  logic in_ready, out_valid, out_last, busy, done;
  tile_t out_tile;
  logic [IW-1:0] out_idx;
  int nvec = 0, nerr = 0, cyc = 0;

  vec_tile_serializer #(.DATA_WIDTH(DW), .LENGTH(LENGTH), .TILE(TILE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .vec_len(vec_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_tile(out_tile), .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic over element indices.
  function automatic int eff_of(input int len);
    return (len > LENGTH) ? LENGTH : len;
  endfunction

  function automatic int nbeats_of(input int len);
    return (eff_of(len) + TILE - 1) / TILE;
  endfunction

  function automatic tile_t exp_tile(input vec_t v, input int len, input int b);
    tile_t t;
    for (int j = 0; j < TILE; j++) begin
      int k;
      k = b * TILE + j;
      t[j] = (k < eff_of(len)) ? v[k] : '0;
    end
    return t;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LENGTH; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic accept(input vec_t v, input int len, output int acc);
    in_vec = v; vec_len = LW'(len); in_valid = 1'b1;
    for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic drain(input vec_t v, input int len, input bit bp, input bit scr);
    int nb, nbeat, last_c, c;
    bit stalled, got_done;
    tile_t pt; logic [IW-1:0] pi; logic pl;
    nb = nbeats_of(len); nbeat = 0; last_c = 0; c = 0; stalled = 0; got_done = 0;
    pt = '0; pi = '0; pl = 1'b0;
    while (c < 400 && !got_done) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scr) begin in_vec = rand_vec(); vec_len = LW'($urandom); end
      @(negedge clk); c++;
      if (stalled && out_valid) begin
        chk("hold_tile", out_tile, pt); chk("hold_idx", out_idx, pi); chk("hold_last", out_last, pl);
      end
      if (nbeat >= nb) chk("no_extra_beat", out_valid, 0);
      chk("busy", busy, 1);
      chk("in_ready_low", in_ready, 0);
      if (out_valid && out_ready && nbeat < nb) begin
        chk("tile", out_tile, exp_tile(v, len, nbeat));
        chk("idx", out_idx, nbeat);
        chk("last", out_last, nbeat == nb - 1);
        if (nbeat == 0 && !bp) chk("latency", c, 1);
        nbeat++; last_c = c;
      end
      stalled = out_valid && !out_ready; pt = out_tile; pi = out_idx; pl = out_last;
      if (done) begin
        got_done = 1;
        chk("beat_count", nbeat, nb);
        chk("done_latency", c, last_c + 1);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("done_seen", got_done, 1);
    @(negedge clk);
    chk("ready_after_done", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    vec_t v, v2;
    int acc, acc2, len;

    // reset
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_last", out_last, 0);
    chk("rst_idx", out_idx, 0); chk("rst_tile", out_tile, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // full ramp vector, no backpressure
    for (int i = 0; i < LENGTH; i++) v[i] = DW'(i);
    accept(v, 128, acc); in_valid = 0;
    drain(v, 128, 0, 1);

    // backpressure
    v = rand_vec(); accept(v, 128, acc); in_valid = 0;
    drain(v, 128, 1, 1);

    // partial length, all 0xFF
    for (int i = 0; i < LENGTH; i++) v[i] = 8'hFF;
    accept(v, 20, acc); in_valid = 0;
    drain(v, 20, 0, 1);

    // zero length
    v = rand_vec(); accept(v, 0, acc); in_valid = 0;
    drain(v, 0, 0, 1);

    // out-of-range length clamps to LENGTH
    v = rand_vec(); accept(v, 200, acc); in_valid = 0;
    drain(v, 200, 1, 1);

    // random lengths with backpressure
    repeat (6) begin
      v = rand_vec(); len = $urandom_range(0, 128);
      accept(v, len, acc); in_valid = 0;
      drain(v, len, 1, 1);
    end

    // reset during beat 2
    v = rand_vec(); accept(v, 128, acc); in_valid = 0;
    in_vec = rand_vec(); out_ready = 1;
    @(negedge clk);
    for (int t = 0; t < 20 && !(out_valid && out_idx == 2); t++) @(negedge clk);
    chk("beat2_idx", out_idx, 2);
    chk("beat2_tile", out_tile, exp_tile(v, 128, 2));
    rst_n = 0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0); chk("abort_done", done, 0);
    chk("abort_in_ready", in_ready, 0); chk("abort_tile", out_tile, 0); chk("abort_idx", out_idx, 0);
    rst_n = 1;
    @(negedge clk);
    chk("abort_ready_back", in_ready, 1); chk("abort_no_valid", out_valid, 0); chk("abort_no_done", done, 0);
    @(negedge clk);
    chk("abort_no_done2", done, 0); chk("abort_no_valid2", out_valid, 0);
    v = rand_vec(); accept(v, 40, acc); in_valid = 0;
    drain(v, 40, 0, 1);

    // back-to-back with in_valid held high
    v = rand_vec(); v2 = rand_vec();
    accept(v, 128, acc);
    in_vec = v2; vec_len = 8'd50;
    drain(v, 128, 0, 0);
    accept(v2, 50, acc2); in_valid = 0;
    chk("b2b_spacing", acc2 - acc, nbeats_of(128) + 2);
    drain(v2, 50, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vec_tile_serializer.md
Name: vec_tile_serializer

Overview:
- Output-side counterpart of the element-wise activation stage.
- Captures one full LENGTH-element activation vector (e.g. post-ReLU int8 data) in a single handshake.
- Streams the vector out as TILE-element beats over a valid/ready interface to the buffer/memory writer.
- Supports a runtime valid length: elements at or beyond vec_len are emitted as zero, and beats past the last needed one are not sent.

Parameters:
- DATA_WIDTH, 8, element width in bits (signed, passed through unchanged).
- LENGTH, 128, elements per input vector; must be a multiple of TILE.
- TILE, 16, elements per output beat.
- NBEATS (derived, localparam), LENGTH/TILE.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept a vector.
- in_vec  in  DATA_WIDTH x LENGTH  signed input vector, index 0..LENGTH-1.
- vec_len  in  $clog2(LENGTH+1)  number of valid elements, sampled with in_vec.
- out_valid  out  1  beat present on out_tile.
- out_ready  in  1  downstream accepts beat.
- out_tile  out  DATA_WIDTH x TILE  beat data; element j = buffer[out_idx*TILE + j].
- out_idx  out  max(1,$clog2(NBEATS))  beat index within vector.
- out_last  out  1  current beat is the final beat of this vector.
- busy  out  1  vector held / streaming in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge) clears all state:
  - state returns to IDLE; buffer contents are don't-care.
  - out_valid, out_last, done and busy are 0; out_idx and out_tile are 0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- Reset mid-stream aborts the current vector immediately. No done pulse is produced and no further beats are sent.
- FSM states: IDLE, SEND, FIN.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid&&in_ready, register in_vec and eff_len = min(vec_len, LENGTH).
  - Compute nbeats = ceil(eff_len/TILE) and clear the beat counter.
  - Go to SEND if nbeats>0. Otherwise go to FIN (empty vector: zero beats, done still pulses).
- SEND:
  - in_ready=0, busy=1, out_valid=1.
  - First beat is valid on the cycle after acceptance, so latency is 1 cycle.
  - out_tile element j = buffer[k] if k < eff_len, else 0, where k = out_idx*TILE+j.
  - out_last = (out_idx == nbeats-1).
  - While out_valid && !out_ready, out_tile, out_idx and out_last hold stable. The beat must not be withdrawn.
  - On out_valid&&out_ready: if out_last, go to FIN; otherwise increment out_idx.
- FIN:
  - Lasts exactly one cycle, with done=1, busy=1, out_valid=0, in_ready=0.
  - Next state is IDLE.
  - Minimum spacing between two input acceptances is therefore nbeats+2 cycles.
- Data and width rules:
  - Data is passed bit-exact, with no sign change or saturation.
  - Zero padding uses all-zero bits.
  - vec_len > LENGTH (only possible when LENGTH+1 is not a power of 2) is clamped to LENGTH.
- in_vec and vec_len are ignored outside the accept cycle. Changing them mid-stream does not affect emitted data.
- out_ready may be asserted permanently; the block then emits one beat per cycle.

Test Plan:
- Full vector, out_ready=1:
  - Stimulus: in_vec[i]=i, vec_len=128, defaults.
  - Required: 8 beats on consecutive cycles starting 1 cycle after accept. Beat 3 carries 48..63. out_last only on idx 7. done pulses 1 cycle after beat 7. in_ready=1 the following cycle.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,... pseudo-randomly.
  - Required: every stalled beat is held bit-stable. Beats arrive in order 0..7 with no loss or duplication.
- Partial length:
  - Stimulus: vec_len=20, in_vec[i]=-1 (0xFF) for all i.
  - Required: exactly 2 beats. Beat 0 is all 0xFF. Beat 1 elements 0..3 are 0xFF and elements 4..15 are 0x00. out_last is on beat 1.
- Zero length:
  - Stimulus: vec_len=0.
  - Required: no out_valid. done pulses on the cycle after accept. in_ready returns on the cycle after that.
- Mid-stream changes and reset:
  - Stimulus: change in_vec after accept; then drop rst_n for 1 cycle during beat 2.
  - Required: emitted data equals the captured vector. After reset: out_valid=0 and no done pulse. The next vector is accepted and streamed from idx 0.
- Back-to-back vectors:
  - Stimulus: in_valid held high with two different vectors.
  - Required: second accept occurs exactly nbeats+2 cycles after the first. Data is not mixed between the two vectors.
